// File: rtl/bcd_seq_pkg.sv
// Shared constants, FSM state encoding and digit-slice helper for the BCD digit sequencer.
package bcd_seq_pkg;

  localparam int DIGITS_DEF = 10;
  localparam int BIN_W      = 32;
  localparam int IDX_W      = 4;
  localparam int BCD_W      = DIGITS_DEF * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] v, input logic [IDX_W-1:0] i);
    return v[int'(i)*4 +: 4];
  endfunction

endpackage

// File: rtl/bcd_digit_sequencer_if.sv
// Input word stream, output digit stream, status and FSM debug state of the BCD digit sequencer.
interface bcd_digit_sequencer_if;
  import bcd_seq_pkg::*;

  // Both streams: a transfer happens on a rising clk edge where valid and ready are both 1;
  // the producer holds its payload stable and keeps valid high until that transfer.
  logic [BIN_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [3:0]       dout;
  logic [IDX_W-1:0] dout_idx;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  state_e           state;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_idx, dout_valid, dout_last, busy, state
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_idx, dout_valid, dout_last, busy, state
  );

endinterface

// File: rtl/bcd_lead_digit.sv
// Index of the most significant non-zero BCD digit; 0 when every digit is zero.
module bcd_lead_digit
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic [DIGITS*4-1:0] bcd,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bin_to_dec.sv
// Combinational 32-bit binary to 10-digit BCD converter (shift-and-add-3).
module bin_to_dec (
  input  logic [31:0] bin,
  output logic [39:0] bcd
);

  logic [39:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < 10; d++) begin
        if (acc[d*4 +: 4] >= 4'd5) acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc = {acc[38:0], bin[i]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Converts one binary word to BCD and streams its digits MSD first, one per output handshake.
// Leading-zero suppression is built when BDS_LZ_SUPPRESS_EN is defined.
module bcd_digit_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEF,
  parameter int REG_CONV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_digit_sequencer_if.slave  bus
);

  localparam logic [1:0] CAP_CNT  = 2'(REG_CONV);
  localparam logic [1:0] LOAD_CNT = 2'(REG_CONV + 1);

  state_e           state;
  logic [BIN_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] cap_src;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] idx;
  logic [1:0]       cnt;
  logic             din_ready_q;
  logic [3:0]       dout_q;
  logic             dout_valid_q;
  logic             dout_last_q;
  logic             busy_q;

  bin_to_dec u_bin_to_dec (
    .bin (bin_reg),
    .bcd (conv_bcd)
  );

  if (REG_CONV != 0) begin : g_pipe
    logic [BCD_W-1:0] pipe_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= conv_bcd;
    end
    assign cap_src = pipe_q;
  end else begin : g_direct
    assign cap_src = conv_bcd;
  end

`ifdef BDS_LZ_SUPPRESS_EN
  bcd_lead_digit #(.DIGITS(DIGITS)) u_lead (
    .bcd (bcd_reg),
    .idx (start_idx)
  );
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  assign start_idx = LAST_IDX;
`endif

  // CONV: the capture edge loads bcd_reg, the following edge presents the first digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      idx          <= '0;
      cnt          <= '0;
      din_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid && din_ready_q) begin
            bin_reg     <= bus.din;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt         <= '0;
            state       <= CONV;
          end else begin
            din_ready_q <= 1'b1;
          end
        end
        CONV: begin
          cnt <= cnt + 2'd1;
          if (cnt == CAP_CNT) bcd_reg <= cap_src;
          if (cnt == LOAD_CNT) begin
            idx          <= start_idx;
            dout_q       <= digit_at(bcd_reg, start_idx);
            dout_last_q  <= (start_idx == '0);
            dout_valid_q <= 1'b1;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (bus.dout_ready) begin
            if (idx == '0) begin
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              busy_q       <= 1'b0;
              din_ready_q  <= 1'b1;
              state        <= IDLE;
            end else begin
              idx         <= idx - IDX_W'(1);
              dout_q      <= digit_at(bcd_reg, idx - IDX_W'(1));
              dout_last_q <= (idx == IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_idx   = idx;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state;

endmodule
